// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile-map constants, tile codes and update-entry layout
package tile_pkg;

  localparam int N_TILES     = 36;
  localparam int N_PERIMETER = 24;
  localparam int CENTRE_BASE = N_PERIMETER;
  localparam int ADDR_W      = 6;
  localparam int DATA_W      = 5;
  localparam int FIFO_DEPTH  = 8;

  localparam int CODE_LSB    = 0;
  localparam int CODE_W      = 4;
  localparam int FACE_UP_BIT = 4;

  typedef enum logic [CODE_W-1:0] {
    RED         = 4'd0,
    ORANGE      = 4'd1,
    YELLOW      = 4'd2,
    GREEN       = 4'd3,
    BLUE        = 4'd4,
    NAVY        = 4'd5,
    PURPLE      = 4'd6,
    WHITE       = 4'd7,
    BLACK       = 4'd8,
    SKYBLUE     = 4'd9,
    FORESTGREEN = 4'd10,
    GRAY        = 4'd11
  } tile_code_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } upd_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/tile_map_scheduler.sv
// rtl/tile_map_scheduler.sv - tile-map register file with grouped updates committed atomically in vblank
module tile_map_scheduler
  import tile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              blank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              commit_pulse,
  output logic              err_addr
);

  localparam int                PEND_W = $clog2(FIFO_DEPTH) + 1;
  localparam int                ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] TILE_LIMIT = ADDR_W'(N_TILES);

  sched_state_e       r_state;
  sched_state_e       w_state_next;
  logic [PEND_W-1:0]  r_pending;
  logic [DATA_W-1:0]  r_map [N_TILES];
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_commit;
  logic               r_err;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_push_last;
  logic               w_pop_last;
  logic               w_addr_ok;
  logic [ENTRY_W-1:0] w_pop_bits;
  upd_t               w_push_entry;
  upd_t               w_pop_entry;

  assign wr_ready     = !w_full;
  assign w_push       = wr_valid && !w_full;
  assign w_push_last  = w_push && wr_last;
  assign w_push_entry = '{last: wr_last, addr: wr_addr, data: wr_data};
  assign w_pop        = (r_state == ST_DRAIN) && !w_empty;
  assign w_pop_entry  = upd_t'(w_pop_bits);
  assign w_pop_last   = w_pop && w_pop_entry.last;
  assign w_addr_ok    = (w_pop_entry.addr < TILE_LIMIT);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (ENTRY_W'(w_push_entry)),
    .i_pop       (w_pop),
    .o_pop_data  (w_pop_bits),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Chaining into the next group needs another complete group behind the one just finished.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (blank && (r_pending != '0)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_pop_last && !(blank && (r_pending > PEND_W'(1)))) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_commit  <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      for (int i = 0; i < N_TILES; i++) r_map[i] <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= r_pending + PEND_W'(w_push_last) - PEND_W'(w_pop_last);
      r_commit  <= w_pop_last;
      if (w_pop && !w_addr_ok) r_err <= 1'b1;
      if (w_pop && w_addr_ok)  r_map[w_pop_entry.addr] <= w_pop_entry.data;
      r_rd_data <= (rd_addr < TILE_LIMIT) ? r_map[rd_addr] : '0;
    end
  end

  assign rd_data      = r_rd_data;
  assign busy         = (r_state == ST_DRAIN);
  assign commit_pulse = r_commit;
  assign err_addr     = r_err;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// tb/tb_tile_map_scheduler.sv - directed, table-driven and randomized checks of tile_map_scheduler
module tb_tile_map_scheduler;
  import tile_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_last = 1'b0;
  logic              blank = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              commit_pulse;
  logic              err_addr;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_map [N_TILES];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tab [6];

  typedef struct {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  tile_map_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .blank        (blank),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .commit_pulse (commit_pulse),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    blank    = 1'b0;
    rst      = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N_TILES; i++) exp_map[i] = '0;
  endtask

  task automatic push(input int addr, input logic [DATA_W-1:0] data, input logic last);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(addr);
    wr_data  = data;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Runs n cycles; reports busy cycles, commit count and the cycle numbers (1-based) of the first two commits.
  task automatic run_count(input int n, output int busy_n, output int commit_n,
                           output int c0, output int c1);
    busy_n = 0; commit_n = 0; c0 = 0; c1 = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (busy) busy_n++;
      if (commit_pulse) begin
        commit_n++;
        if (commit_n == 1) c0 = i;
        if (commit_n == 2) c1 = i;
      end
    end
  endtask

  task automatic check_map(input string name);
    for (int i = 0; i < N_TILES; i++) begin
      rd_addr = ADDR_W'(i);
      tick();
      chk($sformatf("%s[%0d]", name, i), 32'(rd_data), 32'(exp_map[i]));
    end
  endtask

  task automatic random_phase(input int n_cycles);
    logic [DATA_W-1:0] m_map [N_TILES];
    ent_t              q [$];
    ent_t              e;
    ent_t              cur;
    int                m_pend;
    bit                m_drain, m_err, have_cur, do_push, drain_next, commit_next;
    int                grp_left;
    logic [DATA_W-1:0] exp_rd;
    logic [8:0]        act_v, exp_v;
    for (int i = 0; i < N_TILES; i++) m_map[i] = '0;
    m_pend = 0; m_drain = 0; m_err = 0; have_cur = 0; grp_left = 0;
    for (int c = 0; c < n_cycles; c++) begin
      if ($urandom_range(0, 24) == 0) blank = ~blank;
      rd_addr = ADDR_W'($urandom_range(0, 39));
      if (!have_cur) begin
        if (grp_left == 0) grp_left = $urandom_range(1, 4);
        cur.addr = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom_range(36, 63))
                                                : ADDR_W'($urandom_range(0, 35));
        cur.data = DATA_W'($urandom);
        cur.last = (grp_left == 1);
        have_cur = 1;
      end
      wr_valid = have_cur && ($urandom_range(0, 3) != 0);
      wr_addr  = cur.addr;
      wr_data  = cur.data;
      wr_last  = cur.last;

      exp_rd      = (rd_addr < ADDR_W'(N_TILES)) ? m_map[rd_addr] : '0;
      do_push     = wr_valid && (q.size() < FIFO_DEPTH);
      commit_next = 0;
      drain_next  = m_drain;
      if (m_drain && q.size() > 0) begin
        e = q.pop_front();
        if (e.addr < ADDR_W'(N_TILES)) m_map[e.addr] = e.data;
        else m_err = 1;
        if (e.last) begin
          m_pend--;
          commit_next = 1;
          drain_next  = blank && (m_pend > 0);
        end
      end else if (!m_drain) begin
        drain_next = blank && (m_pend > 0);
      end
      if (do_push) begin
        q.push_back(cur);
        if (cur.last) m_pend++;
        grp_left--;
        have_cur = 0;
      end
      m_drain = drain_next;

      tick();
      act_v = {wr_ready, busy, commit_pulse, err_addr, rd_data};
      exp_v = {q.size() < FIFO_DEPTH, m_drain, commit_next, m_err, exp_rd};
      chk($sformatf("rand cycle %0d {ready,busy,commit,err,rd}", c), 32'(act_v), 32'(exp_v));
    end
    wr_valid = 1'b0;
    blank    = 1'b0;
  endtask

  initial begin
    int b, cn, c0, c1;

    // Reset state and full read sweep.
    do_reset();
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset commit", 32'(commit_pulse), 32'd0);
    chk("reset err", 32'(err_addr), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    check_map("reset map");

    // Simple two-entry group held until blank.
    push(3, 5'h12, 1'b0);
    push(7, 5'h04, 1'b1);
    run_count(4, b, cn, c0, c1);
    chk("no commit outside blank", 32'(cn + b), 32'd0);
    blank = 1'b1;
    run_count(8, b, cn, c0, c1);
    blank = 1'b0;
    chk("grp1 busy cycles", 32'(b), 32'd2);
    chk("grp1 commits", 32'(cn), 32'd1);
    chk("grp1 commit cycle", 32'(c0), 32'd3);
    rd_tab[0] = '{addr: 6'd3,  exp: 5'h12};
    rd_tab[1] = '{addr: 6'd7,  exp: 5'h04};
    rd_tab[2] = '{addr: 6'd0,  exp: 5'h00};
    rd_tab[3] = '{addr: 6'd35, exp: 5'h00};
    rd_tab[4] = '{addr: 6'd40, exp: 5'h00};
    rd_tab[5] = '{addr: 6'd63, exp: 5'h00};
    foreach (rd_tab[i]) begin
      rd_addr = rd_tab[i].addr;
      tick();
      chk($sformatf("table read addr %0d", rd_tab[i].addr), 32'(rd_data), 32'(rd_tab[i].exp));
    end

    // Eight non-last entries fill the queue; nothing commits.
    for (int i = 0; i < FIFO_DEPTH; i++) push(i, DATA_W'(i), 1'b0);
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    push(9, 5'h1F, 1'b1);
    chk("held-off wr_ready", 32'(wr_ready), 32'd0);
    blank = 1'b1;
    run_count(6, b, cn, c0, c1);
    chk("full no-last busy+commit", 32'(b + cn), 32'd0);
    do_reset();

    // Two queued groups (2 + 3) drain back to back.
    push(0, 5'h10, 1'b0);
    push(1, 5'h11, 1'b1);
    push(24, 5'h09, 1'b0);
    push(25, 5'h0A, 1'b0);
    push(35, 5'h1B, 1'b1);
    blank = 1'b1;
    run_count(10, b, cn, c0, c1);
    blank = 1'b0;
    chk("2grp busy cycles", 32'(b), 32'd5);
    chk("2grp commits", 32'(cn), 32'd2);
    chk("2grp first commit", 32'(c0), 32'd3);
    chk("2grp second commit", 32'(c1), 32'd6);
    exp_map[0] = 5'h10; exp_map[1] = 5'h11; exp_map[24] = 5'h09;
    exp_map[25] = 5'h0A; exp_map[35] = 5'h1B;
    check_map("2grp map");

    // Blank drops after the first pop of a 4-entry group.
    push(10, 5'h01, 1'b0);
    push(11, 5'h02, 1'b0);
    push(12, 5'h03, 1'b0);
    push(13, 5'h14, 1'b1);
    push(20, 5'h1B, 1'b1);
    blank = 1'b1;
    tick();
    tick();
    blank = 1'b0;
    run_count(10, b, cn, c0, c1);
    chk("blank-drop commits", 32'(cn), 32'd1);
    chk("blank-drop commit cycle", 32'(c0), 32'd3);
    chk("blank-drop busy cycles", 32'(b), 32'd2);
    blank = 1'b1;
    run_count(5, b, cn, c0, c1);
    blank = 1'b0;
    chk("next-blank commits", 32'(cn), 32'd1);
    chk("next-blank commit cycle", 32'(c0), 32'd2);
    exp_map[10] = 5'h01; exp_map[11] = 5'h02; exp_map[12] = 5'h03;
    exp_map[13] = 5'h14; exp_map[20] = 5'h1B;
    check_map("blank-drop map");

    // Out-of-range index is discarded and flagged.
    push(40, 5'h1F, 1'b1);
    blank = 1'b1;
    run_count(5, b, cn, c0, c1);
    blank = 1'b0;
    chk("bad addr commit", 32'(cn), 32'd1);
    chk("bad addr err", 32'(err_addr), 32'd1);
    check_map("bad addr map");

    // Reset asserted in the middle of a drain.
    push(5, 5'h07, 1'b0);
    push(6, 5'h08, 1'b0);
    push(7, 5'h19, 1'b1);
    blank = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst commit", 32'(commit_pulse), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N_TILES; i++) exp_map[i] = '0;
    run_count(6, b, cn, c0, c1);
    blank = 1'b0;
    chk("midrst no activity", 32'(b + cn), 32'd0);
    chk("midrst err", 32'(err_addr), 32'd0);
    chk("midrst wr_ready", 32'(wr_ready), 32'd1);
    check_map("midrst map");

    // Randomized traffic against the queue-based reference.
    do_reset();
    random_phase(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_map_scheduler.md
Name: tile_map_scheduler

Overview:
Owns the board tile-map register file, 36 entries: 24 perimeter tiles plus 12 centre flip tiles. The display pipeline reads it every pixel. Game logic queues updates in write groups. A group is committed atomically, and only inside vertical blanking, so a frame never shows a half-applied move.

Parameters:
N_TILES, 36, number of tile-map entries (index 0-23 perimeter, 24-35 centre)
ADDR_W, 6, tile index width
DATA_W, 5, entry width: [3:0] tile colour/art code, [4] face-up flag
FIFO_DEPTH, 8, update queue depth (power of two)

Ports:
clk  in  1  pixel/system clock
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  update request valid
wr_ready  out  1  queue can accept this cycle
wr_addr  in  ADDR_W  tile index to update
wr_data  in  DATA_W  new entry value
wr_last  in  1  marks final update of a group
blank  in  1  vertical blanking from LCD timing controller (level)
rd_addr  in  ADDR_W  display-side tile index
rd_data  out  DATA_W  display-side tile entry, registered
busy  out  1  group commit in progress
commit_pulse  out  1  one-cycle strobe after a group is fully applied
err_addr  out  1  sticky: an out-of-range index was popped

Behaviour:
- Reset (async, rst=1):
  - all tile entries = 0; FIFO empty; pending_groups = 0; state = IDLE.
  - rd_data = 0, busy = 0, commit_pulse = 0, err_addr = 0.
  - wr_ready = 1 from the first clock after release.
- Push:
  - wr_ready = !full, computed from registered FIFO count.
  - Push happens when wr_valid && wr_ready, storing {wr_last, wr_addr, wr_data}.
  - When full, no push that cycle even if a pop occurs in the same cycle.
- pending_groups counter (0..FIFO_DEPTH):
  - +1 on a push with wr_last; -1 on a pop with last.
  - Both in the same cycle: unchanged.
- FSM:
  - IDLE -> DRAIN when blank && pending_groups > 0.
  - DRAIN: pop one entry per cycle and write it into the tile map in that same clock edge.
  - A popped entry with addr >= N_TILES is discarded and sets err_addr (cleared only by rst).
  - On popping a last entry:
    - if blank && pending_groups (after decrement) > 0, stay in DRAIN;
    - else go to IDLE.
  - commit_pulse = 1 for the cycle after the last-entry pop, in both cases.
- Blanking boundaries:
  - If blank falls mid-group, the group still drains to completion, at most FIFO_DEPTH cycles.
  - No new group starts outside blank.
- Entries without wr_last are never committed until their terminating entry arrives.
  - A full FIFO holding no last entry deadlocks by design; game logic must keep groups <= FIFO_DEPTH.
- busy = (state == DRAIN).
- Read port:
  - rd_data <= map[rd_addr] each clock (1-cycle latency).
  - rd_addr >= N_TILES reads 0.
  - Same-cycle read and commit to the same index returns the old value.
- Reset mid-DRAIN discards the queue and clears the map; no commit_pulse is issued.

Decomposition:
- Shared package tile_pkg holds:
  - tile code constants: RED=0, ORANGE=1, YELLOW=2, GREEN=3, BLUE=4, NAVY=5, PURPLE=6, WHITE=7, BLACK=8, SKYBLUE=9, FORESTGREEN=10, GRAY=11;
  - N_TILES, the perimeter/centre index split, and the entry field offsets.
- One sub-module: sync_fifo (parameterised width/depth, registered count, full/empty), reusable elsewhere.
- FSM, pending_groups counter and tile map stay in the top.

Test Plan:
- Reset, then read all 36 indices -> rd_data = 0 every read, one cycle after rd_addr; wr_ready = 1.
- blank=0; push (3,5'h12), (7,5'h04, last) -> nothing committed. Raise blank -> busy for 2 cycles; index 3 = 5'h12, index 7 = 5'h04; commit_pulse once, 1 cycle after the second pop.
- Push 8 non-last entries -> wr_ready = 0 after the 8th; a 9th wr_valid is held off; no commit even with blank=1.
- Two groups queued (2 + 3 entries), blank high 10 cycles -> 5 consecutive pops; two commit_pulses 2 cycles and 3 cycles after start.
- Group of 4 starts; blank drops after the first pop -> remaining 3 still committed; a second queued group waits for the next blank rise.
- Push addr 40 as last -> err_addr = 1 after the commit; map unchanged.
- Assert rst mid-DRAIN -> map and FIFO cleared; busy = 0; no commit_pulse.
